// File: rtl/lsu_exec.sv
// Load/store execute stage: effective address, alignment check, single-outstanding
// memory request, and lane-aligned/extended load writeback.
module lsu_exec #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              zero_ext,
    input  logic              is_nop,
    input  logic [1:0]        size,
    input  logic [4:0]        rd,
    input  logic [11:0]       imm,
    input  logic [31:0]       rs1_val,
    input  logic [31:0]       rs2_val,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              st_done,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              accept_c;
    logic              misal_c;
    logic              go_c;
    logic              capture_c;
    logic [ADDR_W-1:0] ea_c;

    logic [1:0]        ea_lo_p1;
    logic [1:0]        size_p1;
    logic              zext_p1;
    logic              load_p1;
    logic [4:0]        rd_p1;

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == 2'b01) && lo[0]) || (sz[1] && (lo != 2'b00));
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] lo,
                                                input logic [1:0] sz, input logic zx);
        logic [31:0] lane;
        lane = d >> {lo, 3'b000};
        case (sz)
            2'b00:   return zx ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   return zx ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: return d;
        endcase
    endfunction

    assign in_ready  = (state == IDLE);
    assign ea_c      = rs1_val[ADDR_W-1:0] + {{(ADDR_W-12){imm[11]}}, imm};
    assign accept_c  = in_valid && in_ready && !is_nop;
    assign misal_c   = is_misaligned(size, ea_c[1:0]);
    assign go_c      = accept_c && !misal_c;
    assign capture_c = (state == WAIT) && mem_resp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go_c) state_nxt = REQ;
            REQ:  if (mem_req_ready) state_nxt = load_p1 ? WAIT : IDLE;
            WAIT: if (mem_resp_valid) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Op capture stage: fields needed after the request has been issued.
    always_ff @(posedge clk) begin
        if (go_c) begin
            ea_lo_p1 <= ea_c[1:0];
            size_p1  <= size;
            zext_p1  <= zero_ext;
            load_p1  <= is_load;
            rd_p1    <= rd;
        end
    end

    // Registered outputs; request fields only change on accept, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= 4'h0;
            mem_wdata     <= 32'h0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'h0;
            st_done       <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            mem_req_valid <= (state_nxt == REQ);
            st_done       <= (state == REQ) && mem_req_ready && !load_p1;
            misalign      <= accept_c && misal_c;
            wb_valid      <= capture_c && (rd_p1 != 5'd0);
            if (go_c) begin
                mem_we    <= !is_load;
                mem_addr  <= {ea_c[ADDR_W-1:2], 2'b00};
                mem_be    <= byte_en(size, ea_c[1:0]);
                mem_wdata <= store_lanes(size, rs2_val);
            end
            if (capture_c) begin
                wb_rd   <= rd_p1;
                wb_data <= load_extend(mem_rdata, ea_lo_p1, size_p1, zext_p1);
            end
        end
    end

endmodule

// File: tb/tb_lsu_exec.sv
// Directed bench for lsu_exec: stimulus pushes expected events into a queue,
// an independent monitor pops and compares whenever the DUT emits an event.
module tb_lsu_exec;

    localparam int K_REQ = 0;
    localparam int K_WB  = 1;
    localparam int K_ST  = 2;
    localparam int K_MIS = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        zero_ext = 1'b0;
    logic        is_nop = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [4:0]  rd = 5'd0;
    logic [11:0] imm = 12'h0;
    logic [31:0] rs1_val = 32'h0;
    logic [31:0] rs2_val = 32'h0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        misalign;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    lsu_exec #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .zero_ext(zero_ext), .is_nop(is_nop),
        .size(size), .rd(rd), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .misalign(misalign)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic expect_evt(input int k);
        exp_t e;
        n_checks++;
        if (q.size() == 0 || q[0].kind != k) begin
            n_fail++;
            $display("FAIL event_order: got event kind %0d, want kind %0d (queue %0d)",
                     k, (q.size() == 0) ? -1 : q[0].kind, q.size());
        end else begin
            e = q.pop_front();
            if (k == K_REQ) begin
                chk("req_we", {31'h0, mem_we}, {31'h0, e.we});
                chk("req_addr", mem_addr, e.addr);
                chk("req_be", {28'h0, mem_be}, {28'h0, e.be});
                if (e.we) chk("req_wdata", mem_wdata, e.wdata);
            end else if (k == K_WB) begin
                chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    endtask

    // Monitor: every DUT event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) expect_evt(K_REQ);
            if (wb_valid) expect_evt(K_WB);
            if (st_done) expect_evt(K_ST);
            if (misalign) expect_evt(K_MIS);
        end
    end

    task automatic push(input int k, input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.rd = r; e.data = d;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got in_ready=0 after %0d cycles, want 1", nm, n);
        end
    endtask

    task automatic run_op(input logic ld, input logic zx, input logic nop, input logic [1:0] sz,
                          input logic [4:0] rd_i, input logic [11:0] imm_i,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input int req_dly, input int rsp_dly, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_wb,
                          input logic e_mis, input string nm);
        wait_idle(nm);
        if (!nop) begin
            if (e_mis) begin
                push(K_MIS, 0, 0, 0, 0, 0, 0);
            end else begin
                push(K_REQ, !ld, e_addr, e_be, e_wdata, 0, 0);
                if (!ld) push(K_ST, 0, 0, 0, 0, 0, 0);
                else if (rd_i != 5'd0) push(K_WB, 0, 0, 0, 0, rd_i, e_wb);
            end
        end
        is_load = ld; zero_ext = zx; is_nop = nop; size = sz; rd = rd_i;
        imm = imm_i; rs1_val = rs1; rs2_val = rs2; in_valid = 1'b1;
        mem_req_ready = nop || e_mis;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (nop || e_mis) begin
            chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h1);
            chk({nm, "_no_req"}, {31'h0, mem_req_valid}, 32'h0);
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            chk({nm, "_no_req2"}, {31'h0, mem_req_valid}, 32'h0);
            return;
        end
        chk({nm, "_req_valid"}, {31'h0, mem_req_valid}, 32'h1);
        // Backpressure cycles; a stray response here must be ignored.
        for (int i = 0; i < req_dly; i++) begin
            mem_resp_valid = 1'b1;
            chk({nm, "_hold_valid"}, {31'h0, mem_req_valid}, 32'h1);
            chk({nm, "_hold_addr"}, mem_addr, e_addr);
            chk({nm, "_hold_be"}, {28'h0, mem_be}, {28'h0, e_be});
            if (!ld) chk({nm, "_hold_wdata"}, mem_wdata, e_wdata);
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        if (!ld) begin
            chk({nm, "_st_done"}, {31'h0, st_done}, 32'h1);
            chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h1);
            return;
        end
        chk({nm, "_req_drop"}, {31'h0, mem_req_valid}, 32'h0);
        for (int i = 0; i < rsp_dly; i++) begin
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        mem_rdata = 32'h5A5A5A5A;
        chk({nm, "_wb_valid"}, {31'h0, wb_valid}, {31'h0, rd_i != 5'd0});
        chk({nm, "_busy"}, {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        chk({nm, "_wb_pulse"}, {31'h0, wb_valid}, 32'h0);
        chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while waiting for a load response abandons the load.
        push(K_REQ, 0, 32'h9000, 4'hF, 0, 0, 0);
        is_load = 1; zero_ext = 0; is_nop = 0; size = 2'b10; rd = 5'd3;
        imm = 12'h0; rs1_val = 32'h9000; rs2_val = 32'h77778888; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("wait_busy", {31'h0, in_ready}, 32'h0);
        chk("wait_addr", mem_addr, 32'h9000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_mid_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_be", {28'h0, mem_be}, 32'h0);
        chk("rst_mid_wdata", mem_wdata, 32'h0);
        chk("rst_mid_misc", {22'h0, mem_we, wb_valid, st_done, misalign, wb_rd, 1'b0},
            32'h0);
        chk("rst_mid_wb_data", wb_data, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h11112222;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        chk("stray_resp_wb", {31'h0, wb_valid}, 32'h0);
        @(posedge clk); #1;
        chk("stray_resp_wb2", {31'h0, wb_valid}, 32'h0);
        chk("stray_resp_ready", {31'h0, in_ready}, 32'h1);

        //     ld zx nop sz     rd     imm      rs1           rs2         rq rs rdata         addr          be       wdata         wb            mis
        run_op(1, 0, 0, 2'b10, 5'd5,  12'hFFC, 32'h00001000, 32'h0,       0, 0, 32'hDEADBEEF, 32'h00000FFC, 4'b1111, 32'h0,        32'hDEADBEEF, 0, "lw");
        run_op(1, 0, 0, 2'b00, 5'd7,  12'h003, 32'h00002000, 32'h0,       0, 0, 32'h80AABBCC, 32'h00002000, 4'b1000, 32'h0,        32'hFFFFFF80, 0, "lb");
        run_op(1, 1, 0, 2'b00, 5'd8,  12'h003, 32'h00002000, 32'h0,       0, 0, 32'h80AABBCC, 32'h00002000, 4'b1000, 32'h0,        32'h00000080, 0, "lbu");
        run_op(0, 0, 0, 2'b01, 5'd0,  12'h002, 32'h00003000, 32'h1234ABCD, 3, 0, 32'h0,       32'h00003000, 4'b1100, 32'hABCDABCD, 32'h0,        0, "sh");
        run_op(1, 0, 0, 2'b10, 5'd9,  12'h002, 32'h00004000, 32'h0,       0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1, "lw_mis");
        run_op(0, 0, 0, 2'b01, 5'd0,  12'h001, 32'h00004000, 32'h00005555, 0, 0, 32'h0,       32'h0,        4'b0000, 32'h0,        32'h0,        1, "sh_mis");
        run_op(1, 0, 1, 2'b10, 5'd4,  12'h000, 32'h00000000, 32'h0,       0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        0, "nop");
        run_op(1, 0, 0, 2'b01, 5'd0,  12'h002, 32'h00005000, 32'h0,       0, 0, 32'h12345678, 32'h00005000, 4'b1100, 32'h0,        32'h0,        0, "lh_rd0");
        run_op(1, 0, 0, 2'b01, 5'd10, 12'hFFE, 32'h00006000, 32'h0,       1, 2, 32'h80011234, 32'h00005FFC, 4'b1100, 32'h0,        32'hFFFF8001, 0, "lh_neg");
        run_op(1, 1, 0, 2'b01, 5'd11, 12'h000, 32'h00006000, 32'h0,       0, 1, 32'h1234F00D, 32'h00006000, 4'b0011, 32'h0,        32'h0000F00D, 0, "lhu");
        run_op(0, 0, 0, 2'b00, 5'd0,  12'h001, 32'h00007000, 32'h000000AB, 0, 0, 32'h0,       32'h00007000, 4'b0010, 32'hABABABAB, 32'h0,        0, "sb");
        run_op(0, 0, 0, 2'b11, 5'd0,  12'h004, 32'h00008000, 32'hCAFEF00D, 1, 0, 32'h0,       32'h00008004, 4'b1111, 32'hCAFEF00D, 32'h0,        0, "sw");

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
